// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared slot state encoding and defaults for conv_sched
package conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int KSIZE_DEF  = 9;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        SLOT_IDLE  = 3'd0,
        SLOT_START = 3'd1,
        SLOT_BUSY  = 3'd2,
        SLOT_DONE  = 3'd3,
        SLOT_CLR   = 3'd4
    } slot_state_t;

endpackage

// File: rtl/conv_sched_slot.sv
// rtl/conv_sched_slot.sv - one engine slot: FSM, held operands, result capture
// Optional per-slot watchdog enabled by CONV_SCHED_TIMEOUT_EN.
module conv_sched_slot
    import conv_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int KSIZE       = KSIZE_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept,
    input  logic                    retire,
    input  logic [KSIZE*DATA_W-1:0] job_im,
    input  logic [KSIZE*DATA_W-1:0] job_iw,
    input  logic [DATA_W-1:0]       job_ib,
    input  logic                    pe_valid,
    input  logic [DATA_W-1:0]       pe_om,
    output logic [2:0]              state,
    output logic [KSIZE*DATA_W-1:0] op_im,
    output logic [KSIZE*DATA_W-1:0] op_iw,
    output logic [DATA_W-1:0]       op_ib,
    output logic [DATA_W-1:0]       res,
    output logic                    err
);

    slot_state_t st;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_err;
    assign err = wd_err;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign err = 1'b0;
`endif

    assign state = st;

    // Operands load only on accept, so the engine sees them stable until CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= SLOT_IDLE;
            op_im <= '0;
            op_iw <= '0;
            op_ib <= '0;
            res   <= DATA_W'(FP16_ZERO);
`ifdef CONV_SCHED_TIMEOUT_EN
            wd_cnt <= '0;
            wd_err <= 1'b0;
`endif
        end else begin
            case (st)
                SLOT_IDLE: begin
                    if (accept) begin
                        op_im <= job_im;
                        op_iw <= job_iw;
                        op_ib <= job_ib;
                        st    <= SLOT_START;
                    end
                end
                SLOT_START: begin
                    st <= SLOT_BUSY;
`ifdef CONV_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                SLOT_BUSY: begin
                    if (pe_valid) begin
                        res <= pe_om;
                        st  <= SLOT_DONE;
`ifdef CONV_SCHED_TIMEOUT_EN
                        wd_err <= 1'b0;
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        res    <= DATA_W'(FP16_ZERO);
                        wd_err <= 1'b1;
                        st     <= SLOT_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                SLOT_DONE: begin
                    if (retire) st <= SLOT_CLR;
                end
                SLOT_CLR: st <= SLOT_IDLE;
                default:  st <= SLOT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - in-order round-robin scheduler over NUM_PE conv engines
// Watchdog per slot enabled by CONV_SCHED_TIMEOUT_EN.
module conv_sched
    import conv_pkg::*;
#(
    parameter int NUM_PE      = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int KSIZE       = KSIZE_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [KSIZE*DATA_W-1:0]        job_im,
    input  logic [KSIZE*DATA_W-1:0]        job_iw,
    input  logic [DATA_W-1:0]              job_ib,
    output logic [NUM_PE*KSIZE*DATA_W-1:0] pe_im,
    output logic [NUM_PE*KSIZE*DATA_W-1:0] pe_iw,
    output logic [NUM_PE*DATA_W-1:0]       pe_ib,
    output logic [NUM_PE-1:0]              pe_start,
    output logic [NUM_PE-1:0]              pe_rst_n,
    input  logic [NUM_PE-1:0]              pe_valid,
    input  logic [NUM_PE*DATA_W-1:0]       pe_om,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [DATA_W-1:0]              res_data,
    output logic                           res_err,
    output logic                           busy
);

    localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [2:0]        st      [NUM_PE];
    logic [DATA_W-1:0] res_arr [NUM_PE];
    logic [NUM_PE-1:0] err_vec, busy_vec;
    logic              accept, retire;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_PE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign job_ready = (st[wr_ptr] == SLOT_IDLE);
    assign res_valid = (st[rd_ptr] == SLOT_DONE);
    assign res_data  = res_arr[rd_ptr];
    assign res_err   = err_vec[rd_ptr];
    assign accept    = job_valid && job_ready;
    assign retire    = res_valid && res_ready;
    assign busy      = |busy_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= ptr_next(wr_ptr);
            if (retire) rd_ptr <= ptr_next(rd_ptr);
        end
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_slot
        conv_sched_slot #(
            .DATA_W      (DATA_W),
            .KSIZE       (KSIZE),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .accept   (accept && (wr_ptr == PTR_W'(i))),
            .retire   (retire && (rd_ptr == PTR_W'(i))),
            .job_im   (job_im),
            .job_iw   (job_iw),
            .job_ib   (job_ib),
            .pe_valid (pe_valid[i]),
            .pe_om    (pe_om[i*DATA_W +: DATA_W]),
            .state    (st[i]),
            .op_im    (pe_im[i*KSIZE*DATA_W +: KSIZE*DATA_W]),
            .op_iw    (pe_iw[i*KSIZE*DATA_W +: KSIZE*DATA_W]),
            .op_ib    (pe_ib[i*DATA_W +: DATA_W]),
            .res      (res_arr[i]),
            .err      (err_vec[i])
        );

        // Engine reset follows the global reset as well as the CLR pulse.
        assign pe_start[i] = (st[i] == SLOT_START);
        assign pe_rst_n[i] = rst_n && (st[i] != SLOT_CLR);
        assign busy_vec[i] = (st[i] != SLOT_IDLE);
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

In-order job scheduler that shares a pool of NUM_PE 3x3 convolution engines between a single upstream job stream and a single downstream result stream. Each job is a 9-element FP16 window, 9 FP16 weights and an FP16 bias. The scheduler dispatches jobs round-robin, holds each engine's operands stable while it computes, and captures its result. It retires results in dispatch order, then pulses a per-engine local reset so the engine's sticky valid clears before reuse. It sits between the operand fetch logic and the output write-back buffer.

## Interface
- NUM_PE, 4, number of engines managed (>=2, need not be a power of two)
- DATA_W, 16, element width (FP16)
- KSIZE, 9, elements per window/kernel
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with CONV_SCHED_TIMEOUT_EN)
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler accepts job this cycle
- job_im  in  KSIZE*DATA_W  window, element k at [DATA_W*k +: DATA_W]
- job_iw  in  KSIZE*DATA_W  weights, same packing
- job_ib  in  DATA_W  bias
- pe_im  out  NUM_PE*KSIZE*DATA_W  per-engine held window (engine i at slice i)
- pe_iw  out  NUM_PE*KSIZE*DATA_W  per-engine held weights
- pe_ib  out  NUM_PE*DATA_W  per-engine held bias
- pe_start  out  NUM_PE  one-cycle start pulse per engine (drives engine conv_ready)
- pe_rst_n  out  NUM_PE  per-engine local active-low reset
- pe_valid  in  NUM_PE  engine conv_valid (sticky until engine reset)
- pe_om  in  NUM_PE*DATA_W  engine results
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  DATA_W  result
- res_err  out  1  result was forced by watchdog
- busy  out  1  any engine slot not IDLE

## Operation
- Per-slot FSM: IDLE -> START -> BUSY -> DONE -> CLR -> IDLE.
- IDLE: slot free. When wr_ptr==i and job_valid&&job_ready: latch job_im/iw/ib into slot i, go START.
- START: pe_start[i]=1 for exactly this cycle; go BUSY.
- BUSY: on first cycle pe_valid[i]==1, capture pe_om slice into the slot result register with err=0, go DONE.
- DONE: result held. When rd_ptr==i, res_valid=1, and a res_ready handshake moves the slot to CLR.
- CLR: pe_rst_n[i]=0 for exactly this cycle; go IDLE.
- job_ready = (slot[wr_ptr]==IDLE). res_valid = (slot[rd_ptr]==DONE). res_data/res_err muxed from slot rd_ptr.
- wr_ptr advances on accept and rd_ptr on retire, each wrapping NUM_PE-1 -> 0.
- Operand registers for a slot change only on accept, so they are stable from START through CLR.
- pe_valid is ignored outside BUSY, which covers a stale sticky valid.
- Dispatch and retire in the same cycle target different slots and both proceed.
- pe_rst_n[i] = rst_n AND (slot[i]!=CLR), so engines are held in reset while rst_n is low.
- busy = OR over slots of (state!=IDLE).

## Timing
- Reset values: job_ready=1, pe_start=0, pe_rst_n=0 while rst_n low then 1, res_valid=0, res_data=0, res_err=0, busy=0, all operand outputs=0, pointers=0, all slots IDLE.
- Accept at edge T: pe_start high in cycle T+1, BUSY from T+2.
- pe_valid seen high in cycle B: res_valid can assert in B+1.
- Retire at edge R: pe_rst_n low in cycle R+1, slot IDLE (job_ready) from R+2.
- Minimum per-slot reuse interval: accept-to-accept = 4 cycles + engine latency + downstream stall.
- res_valid, once high, stays high with res_data and res_err stable until res_ready.
- Reset mid-operation discards all in-flight jobs and takes effect asynchronously.

## Configuration
- CONV_SCHED_TIMEOUT_EN defined: each slot has a cycle counter, cleared on START and counting in BUSY. If it reaches TIMEOUT_CYC without pe_valid, the slot captures 16'h0000 with err=1 and goes DONE. The result is still retired in order, then CLR resets the hung engine.
- CONV_SCHED_TIMEOUT_EN undefined: no counters, BUSY waits indefinitely, res_err is constant 0, and the port is retained.

## Structure
- Shared package conv_pkg: slot state encoding (IDLE=0, START=1, BUSY=2, DONE=3, CLR=4, 3-bit), DATA_W/KSIZE defaults, FP16 zero constant.
- One sub-module, conv_sched_slot: the per-slot FSM, operand and result registers, and optional watchdog, instantiated NUM_PE times in a generate loop.
- The top level holds the pointers, the accept/retire decode and the output mux.

## Test plan
- Single job with engine model of latency 20 returning 16'h3C00 -> pe_start pulse at T+1, res_data=16'h3C00, res_err=0, pe_rst_n[0] low one cycle after retire.
- 8 back-to-back jobs, NUM_PE=4, engine latencies 30/10/25/5 -> results out in job order 0..7 and job_ready low while the next slot is not IDLE.
- res_ready held low 50 cycles with all slots DONE -> job_ready=0, res_valid/res_data stable, no pe_start pulses.
- Stale pe_valid held high during IDLE and START -> not captured; capture happens only in BUSY.
- With CONV_SCHED_TIMEOUT_EN, engine never responds -> after 255 BUSY cycles res_data=16'h0000, res_err=1, pe_rst_n pulse; next job completes normally.
- rst_n asserted while 3 jobs are in flight -> all outputs at reset values immediately, pe_rst_n all 0; after release job_ready=1 and no results appear.
